input_debouncer: RTL and testbench

- Conditions a raw asynchronous level input, such as a push-button or external strobe, into a clean, glitch-free, clock-synchronous level.
- Sits directly upstream of the rising-edge detector stage, which consumes dout as its din.
- Contains a multi-flop synchronizer followed by a counter-qualified debounce FSM.
- Also reports bounce activity: a per-event abort pulse and a saturating abort counter.

---
 rtl/input_debouncer.sv | 153 +++++++++++++++
 tb/tb_input_debouncer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// input_debouncer
//   Turns a raw asynchronous level (push-button, external strobe) into a
//   clean, clock-synchronous level. The input passes through a flop
//   synchronizer chain. A counter-qualified FSM then commits a new level
//   only after DEBOUNCE_CYCLES consecutive equal samples.
//   A qualification that is cut short by a bounce is reported twice:
//   as a one-cycle pulse, and in a saturating event counter.
//
// Ports
//   clk         system clock, rising-edge active
//   rst         asynchronous active-low reset
//   din         raw asynchronous level input
//   dout        debounced level (registered)
//   busy        high while a candidate transition is being qualified (registered)
//   glitch      one-cycle pulse after a qualification is aborted (registered)
//   glitch_cnt  saturating count of glitch pulses since reset (registered)
//   glitch_clr  synchronous clear of glitch_cnt; wins over a same-edge increment
module input_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5,
    parameter int unsigned GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din,
    output logic                dout,
    output logic                busy,
    output logic                glitch,
    output logic [GLITCH_W-1:0] glitch_cnt,
    input  logic                glitch_clr
);

    typedef enum logic [1:0] {
        ST_LOW       = 2'd0,
        ST_RISE_WAIT = 2'd1,
        ST_HIGH      = 2'd2,
        ST_FALL_WAIT = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;
    localparam logic [GLITCH_W-1:0] GLITCH_ONE = GLITCH_W'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   busy_q, busy_d;
    logic                   glitch_q, glitch_d;
    logic [GLITCH_W-1:0]    glitch_cnt_q, glitch_cnt_d;
    logic                   s_c;
    logic                   abort_c;

    // Synchronizer shift chain; only the last stage reaches the FSM
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        s_c    = sync_q[SYNC_STAGES-1];
    end

    // Debounce FSM next-state, stability counter and registered-output inputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort_c = 1'b0;

        unique case (state_q)
            ST_LOW: begin
                if (s_c) begin
                    state_d = ST_RISE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RISE_WAIT: begin
                if (!s_c) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                    abort_c = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!s_c) begin
                    state_d = ST_FALL_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_FALL_WAIT: begin
                if (s_c) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    abort_c = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they line up with the state register
        dout_d   = (state_d == ST_HIGH) || (state_d == ST_FALL_WAIT);
        busy_d   = (state_d == ST_RISE_WAIT) || (state_d == ST_FALL_WAIT);
        glitch_d = abort_c;
    end

    // Saturating abort counter; the clear wins over a same-edge increment
    always_comb begin
        glitch_cnt_d = glitch_cnt_q;
        if (glitch_clr) begin
            glitch_cnt_d = '0;
        end else if (abort_c && (glitch_cnt_q != GLITCH_MAX)) begin
            glitch_cnt_d = glitch_cnt_q + GLITCH_ONE;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q       <= '0;
            state_q      <= ST_LOW;
            cnt_q        <= '0;
            dout_q       <= 1'b0;
            busy_q       <= 1'b0;
            glitch_q     <= 1'b0;
            glitch_cnt_q <= '0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dout_q       <= dout_d;
            busy_q       <= busy_d;
            glitch_q     <= glitch_d;
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign dout       = dout_q;
    assign busy       = busy_q;
    assign glitch     = glitch_q;
    assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer
//   Two instances share every input: one with a 2-bit glitch counter and one
//   with an 8-bit glitch counter. Both are compared against a run-length model
//   of the debounce rule. The model works as follows:
//     - the synchronizer is a plain delay queue;
//     - the committed level changes only after DEBOUNCE_CYCLES consecutive
//       differing samples;
//     - any run broken early counts as a glitch.
//   Directed scenarios also check the fixed latencies and patterns.
module tb_input_debouncer;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;
    localparam int unsigned GW_S = 2;
    localparam int unsigned GW_L = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            din = 1'b0;
    logic            glitch_clr = 1'b0;
    logic            dout_s, busy_s, glitch_s;
    logic [GW_S-1:0] gcnt_s;
    logic            dout_l, busy_l, glitch_l;
    logic [GW_L-1:0] gcnt_l;

    always #5 clk = ~clk;

    input_debouncer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(5), .GLITCH_W(GW_S)) u_dut_s (
        .clk(clk), .rst(rst), .din(din), .dout(dout_s), .busy(busy_s),
        .glitch(glitch_s), .glitch_cnt(gcnt_s), .glitch_clr(glitch_clr)
    );

    input_debouncer #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(5), .GLITCH_W(GW_L)) u_dut_l (
        .clk(clk), .rst(rst), .din(din), .dout(dout_l), .busy(busy_l),
        .glitch(glitch_l), .glitch_cnt(gcnt_l), .glitch_clr(glitch_clr)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit hist[$];
    bit m_level;
    int m_run;
    bit m_glitch;
    int m_cnt_s;
    int m_cnt_l;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < int'(SYNC); i++) hist.push_back(1'b0);
        m_level  = 1'b0;
        m_run    = 0;
        m_glitch = 1'b0;
        m_cnt_s  = 0;
        m_cnt_l  = 0;
    endtask

    // One rising edge of the debounce rule
    task automatic model_edge(input bit d, input bit clr);
        bit s_seen;
        if (!rst) begin
            model_reset();
            return;
        end
        s_seen = hist.pop_front();
        hist.push_back(d);
        m_glitch = 1'b0;
        if (s_seen != m_level) begin
            m_run++;
            if (m_run == int'(DEB)) begin
                m_level = s_seen;
                m_run   = 0;
            end
        end else if (m_run > 0) begin
            m_run    = 0;
            m_glitch = 1'b1;
        end
        if (clr) begin
            m_cnt_s = 0;
            m_cnt_l = 0;
        end else if (m_glitch) begin
            if (m_cnt_s < (1 << GW_S) - 1) m_cnt_s++;
            if (m_cnt_l < (1 << GW_L) - 1) m_cnt_l++;
        end
    endtask

    task automatic compare_all();
        check("dout",   dout_s,   m_level);
        check("busy",   busy_s,   (m_run > 0) ? 1 : 0);
        check("glitch", glitch_s, m_glitch);
        check("gcnt_s", gcnt_s,   m_cnt_s);
        check("dout_l", dout_l,   m_level);
        check("busy_l", busy_l,   (m_run > 0) ? 1 : 0);
        check("glitch_l", glitch_l, m_glitch);
        check("gcnt_l", gcnt_l,   m_cnt_l);
    endtask

    // Drive inputs for the next rising edge, then check after it
    task automatic step(input bit d, input bit clr);
        din        = d;
        glitch_clr = clr;
        @(negedge clk);
        model_edge(d, clr);
        compare_all();
    endtask

    task automatic settle(input bit d);
        for (int i = 0; i < 10; i++) step(d, 1'b0);
    endtask

    int  first;
    int  nglitch;
    int  mask;
    int  ever;
    int  base;
    bit  pat [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    bit  rlevel;
    int  rlen;

    initial begin
        // Asynchronous reset with din high
        #2 rst = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);

        // Release: dout rises exactly SYNC+DEB edges later
        rst   = 1'b1;
        first = 99;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0);
            if (dout_s && first == 99) first = i;
        end
        check("rst_release_lat", first, 6);

        // Clean fall
        first = 99; mask = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b0, 1'b0);
            if (!dout_s && first == 99) first = i;
            if (busy_s) mask |= (1 << i);
        end
        check("fall_lat", first, 6);
        check("fall_busy_mask", mask, 32'h38);

        // Clean rise
        first = 99; mask = 0; nglitch = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0);
            if (dout_s && first == 99) first = i;
            if (busy_s) mask |= (1 << i);
            nglitch += glitch_s;
        end
        check("rise_lat", first, 6);
        check("rise_busy_mask", mask, 32'h38);
        check("rise_glitches", nglitch, 0);

        // Bounce during a rise
        settle(1'b0);
        base  = int'(gcnt_l);
        first = 99; nglitch = 0;
        for (int i = 1; i <= 14; i++) begin
            step((i <= 8) ? pat[i-1] : 1'b1, 1'b0);
            if (dout_s && first == 99) first = i;
            nglitch += glitch_s;
        end
        check("bounce_glitches", nglitch, 1);
        check("bounce_cnt_delta", int'(gcnt_l) - base, 1);
        check("bounce_lat", first, 9);

        // Short pulse never commits
        settle(1'b0);
        nglitch = 0; ever = 0;
        for (int i = 1; i <= 12; i++) begin
            step((i <= 3) ? 1'b1 : 1'b0, 1'b0);
            nglitch += glitch_s;
            ever |= dout_s;
        end
        check("short_glitches", nglitch, 1);
        check("short_dout", ever, 0);
        check("short_busy_end", busy_s, 0);

        // Saturation of the 2-bit counter, then clear racing an abort
        step(1'b0, 1'b1);
        check("sat_cleared", gcnt_s, 0);
        for (int p = 1; p <= 5; p++) begin
            step(1'b1, 1'b0);
            for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
            if (p == 3) check("sat_after3", gcnt_s, 3);
        end
        check("sat_after5", gcnt_s, 3);
        check("sat_l_after5", gcnt_l, 5);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        check("clr_race_glitch", glitch_s, 1);
        check("clr_race_cnt_s", gcnt_s, 0);
        check("clr_race_cnt_l", gcnt_l, 0);
        settle(1'b0);

        // Reset in the middle of a fall qualification
        settle(1'b1);
        check("pre_fall_dout", dout_s, 1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        check("in_fall_busy", busy_s, 1);
        check("in_fall_dout", dout_s, 1);
        #2 rst = 1'b0;
        #1 model_reset();
        check("async_rst_dout", dout_s, 0);
        check("async_rst_busy", busy_s, 0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        rst  = 1'b1;
        ever = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            ever |= busy_s | dout_s;
        end
        check("post_rst_idle", ever, 0);

        // Randomized runs of mixed lengths, with occasional clears
        rlevel = 1'b0;
        for (int n = 0; n < 3000; ) begin
            rlevel = ~rlevel;
            rlen   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 12))
                                                 : int'($urandom_range(1, 5));
            for (int i = 0; i < rlen; i++) begin
                step(rlevel, ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
                n++;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
